wb_uart: RTL and testbench
==========================

WB_UART -- requirements
Module: wb_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud), clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_wb_cyc  input  1  bus cycle active; the parent has already qualified it with the address decode.
REQ-005 SHALL have port i_wb_stb  input  1  strobe.
REQ-006 SHALL have port i_wb_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port i_wb_addr  input  2  register index.
REQ-008 SHALL have port i_wb_data  input  8  write data.
REQ-009 SHALL have port o_wb_ack  output  1  transfer acknowledge.
REQ-010 SHALL have port o_wb_stall  output  1  request not accepted this cycle.
REQ-011 SHALL have port o_wb_data  output  8  read data.
REQ-012 SHALL have port o_uart_tx  output  1  serial line, idle high.

Function
REQ-013 Register map SHALL be: 0 TXDATA (W: start frame; R: last byte written); 1 STATUS (bit0 busy, bits7:1 read 0); 2-3 reserved (read 0x00, writes ignored, still acked).
REQ-014 A request SHALL be accepted on an edge where i_wb_cyc & i_wb_stb & ~o_wb_stall.
REQ-015 o_wb_stall SHALL be combinational: high only when i_wb_cyc & i_wb_stb & i_wb_we & addr==0 & busy; all other requests never stall.
REQ-016 o_wb_ack SHALL be registered, high for exactly one cycle, in the cycle after each accepted request; back-to-back accepted requests SHALL give back-to-back acks.
REQ-017 o_wb_data SHALL be registered with o_wb_ack, valid only while o_wb_ack is high, and 0x00 otherwise.
REQ-018 Frame format SHALL be 8N1, LSB first: start bit 0, data[0]..data[7], stop bit 1, each bit held CLKS_PER_BIT cycles.
REQ-019 An accepted TXDATA write SHALL latch the byte; o_uart_tx SHALL go low on the next edge, and busy SHALL rise on that same edge.
REQ-020 The transmitter SHALL be a state machine IDLE -> START -> DATA(8 bits, 3-bit index) -> STOP -> IDLE, driven by a down-counter reloaded with CLKS_PER_BIT-1 at each bit.
REQ-021 busy SHALL clear on the edge the stop bit completes, exactly 10*CLKS_PER_BIT cycles after it rose; a write stalled until then SHALL be accepted that cycle, with no extra idle gap on the line.
REQ-022 A STATUS read in the same cycle as a frame starts SHALL return busy=1.
REQ-023 i_wb_stb without i_wb_cyc SHALL be ignored: no ack, no state change.

Reset
REQ-024 While reset is high: o_uart_tx=1, busy=0, state=IDLE, o_wb_ack=0, o_wb_data=0x00, TXDATA=0x00, counters 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; the line returns high on the next edge, and no ack is issued for a request in the reset cycle.

Configuration
REQ-026 With macro WB_UART_PARITY_EN defined, an even-parity bit SHALL be sent between data[7] and stop (11 bits, busy 11*CLKS_PER_BIT cycles), and STATUS bit1 SHALL read 1; without it, the 8N1 behaviour above applies and STATUS bit1 SHALL read 0.

Structure
REQ-027 Package wb_uart_pkg SHALL hold the register index constants, the STATUS bit positions, and the transmitter state enum typedef.
REQ-028 Serialisation SHALL be in one sub-module uart_tx_core (byte/start in, busy/tx out); wb_uart SHALL contain only bus decode, ack and readback.

Verification
REQ-029 With CLKS_PER_BIT=4, write 0x55 to addr 0: ack next cycle, tx pattern 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles, busy for 40 cycles.
REQ-030 Read addr 1 immediately after a write -> 0x01; read again after 40 cycles -> 0x00; read addr 0 -> 0x55.
REQ-031 Issue a second write (0xA3) during a frame: stall stays high until busy clears, then the write is accepted; the second start bit follows the first stop bit directly.
REQ-032 Assert reset for 1 cycle at cycle 15 of a frame: tx=1, busy=0 next cycle; a new write 0x0F then transmits correctly.
REQ-033 Read addr 2 and write addr 3 with 0xFF: each gets a single-cycle ack, data 0x00, and tx stays high.
REQ-034 With WB_UART_PARITY_EN, write 0x07: parity bit 1 is sent before stop, frame lasts 44 cycles, STATUS reads 0x03 during the frame.

Source files
------------

// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register indices,
// STATUS bit positions and the transmitter state encoding.
// Optional feature: define WB_UART_PARITY_EN to append an even-parity bit.
package wb_uart_pkg;

    // Register indices on the 2-bit Wishbone address
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    // STATUS register bit positions
    localparam int STATUS_BUSY_BIT   = 0;
    localparam int STATUS_PARITY_BIT = 1;

`ifdef WB_UART_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// Serialiser for one UART frame: start bit, 8 data bits LSB first,
// optional even parity (WB_UART_PARITY_EN), stop bit.
// Every bit is held CLKS_PER_BIT cycles using a reloading down-counter.
// A new frame may be loaded during the final cycle of a stop bit, so
// back-to-back frames leave no idle gap on the line.
module uart_tx_core
    import wb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       ready,
    output logic       tx
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
`ifdef WB_UART_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic bit_done;

    assign bit_done = (cnt_q == 16'd0);
    // A frame can be loaded when idle or as the last stop-bit cycle ends.
    assign ready    = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_done);
    assign busy     = busy_q;
    assign tx       = tx_q;

    // State and datapath registers; reset forces the line idle and aborts any frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= TX_IDLE;
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef WB_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational block.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef WB_UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic: count down within a bit, advance to the next bit at zero
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a variable unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
`ifdef WB_UART_PARITY_EN
        parity_d = parity_q;
`endif

        if ((state_q != TX_IDLE) && !bit_done) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            case (state_q)
                TX_IDLE: ;
                TX_START: begin
                    state_d = TX_DATA;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    cnt_d   = BIT_LAST;
                end
                TX_DATA: begin
                    cnt_d = BIT_LAST;
                    if (idx_q == 3'd7) begin
`ifdef WB_UART_PARITY_EN
                        state_d = TX_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
                TX_PARITY: begin
                    state_d = TX_STOP;
                    tx_d    = 1'b1;
                    cnt_d   = BIT_LAST;
                end
                TX_STOP: begin
                    state_d = TX_IDLE;
                    busy_d  = 1'b0;
                    tx_d    = 1'b1;
                end
                default: begin
                    state_d = TX_IDLE;
                    busy_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            endcase
        end

        // Loading a frame overrides the normal progression.
        if (start && ready) begin
            state_d  = TX_START;
            cnt_d    = BIT_LAST;
            idx_d    = 3'd0;
            shift_d  = data;
            tx_d     = 1'b0;
            busy_d   = 1'b1;
`ifdef WB_UART_PARITY_EN
            parity_d = ^data;
`endif
        end
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone (pipelined) front end for a transmit-only UART: register decode,
// stall/ack generation and readback. Serialisation lives in uart_tx_core.
// Optional feature: define WB_UART_PARITY_EN for an even-parity bit; STATUS
// bit1 then reads 1.
module wb_uart
    import wb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wb_cyc,
    input  logic       i_wb_stb,
    input  logic       i_wb_we,
    input  logic [1:0] i_wb_addr,
    input  logic [7:0] i_wb_data,
    output logic       o_wb_ack,
    output logic       o_wb_stall,
    output logic [7:0] o_wb_data,
    output logic       o_uart_tx
);

    logic       wb_req;
    logic       wb_accept;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_ready;
    logic [7:0] txdata_q;
    logic [7:0] read_word;

    assign wb_req     = i_wb_cyc & i_wb_stb;
    // Only a TXDATA write can stall, and only while a frame cannot be loaded.
    assign o_wb_stall = wb_req & i_wb_we & (i_wb_addr == REG_TXDATA) & ~tx_ready;
    assign wb_accept  = wb_req & ~o_wb_stall;
    assign tx_start   = wb_accept & i_wb_we & (i_wb_addr == REG_TXDATA);

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_core (
        .clk  (clk),
        .reset(reset),
        .start(tx_start),
        .data (i_wb_data),
        .busy (tx_busy),
        .ready(tx_ready),
        .tx   (o_uart_tx)
    );

    // Readback mux for the addressed register
    always_comb begin
        read_word = 8'h00;
        case (i_wb_addr)
            REG_TXDATA: read_word = txdata_q;
            REG_STATUS: begin
                read_word[STATUS_BUSY_BIT]   = tx_busy;
                read_word[STATUS_PARITY_BIT] = PARITY_EN;
            end
            default: ;
        endcase
    end

    // Ack, read data and the TXDATA shadow register
    always_ff @(posedge clk) begin
        if (reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= 8'h00;
            txdata_q  <= 8'h00;
        end else begin
            o_wb_ack  <= wb_accept;
            o_wb_data <= (wb_accept && !i_wb_we) ? read_word : 8'h00;
            if (tx_start) begin
                txdata_q <= i_wb_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Directed bench for wb_uart with CLKS_PER_BIT=4. Inputs are driven and
// outputs sampled 1 time unit after the falling edge. Build with
// WB_UART_PARITY_EN defined to exercise the parity frame format.
module tb_wb_uart;

    localparam int CPB = 4;
`ifdef WB_UART_PARITY_EN
    localparam int       NBITS     = 11;
    localparam logic [7:0] STAT_IDLE = 8'h02;
`else
    localparam int       NBITS     = 10;
    localparam logic [7:0] STAT_IDLE = 8'h00;
`endif
    localparam logic [7:0] STAT_BUSY = STAT_IDLE | 8'h01;
    localparam int       FRAME     = NBITS * CPB;

    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;

    logic       clk;
    logic       reset;
    logic       i_wb_cyc;
    logic       i_wb_stb;
    logic       i_wb_we;
    logic [1:0] i_wb_addr;
    logic [7:0] i_wb_data;
    logic       o_wb_ack;
    logic       o_wb_stall;
    logic [7:0] o_wb_data;
    logic       o_uart_tx;

    int n_checks = 0;
    int n_errors = 0;

    wb_uart #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_wb_cyc  (i_wb_cyc),
        .i_wb_stb  (i_wb_stb),
        .i_wb_we   (i_wb_we),
        .i_wb_addr (i_wb_addr),
        .i_wb_data (i_wb_data),
        .o_wb_ack  (o_wb_ack),
        .o_wb_stall(o_wb_stall),
        .o_wb_data (o_wb_data),
        .o_uart_tx (o_uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for bit position idx of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef WB_UART_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_req(input logic cyc, input logic stb, input logic we,
                           input logic [1:0] addr, input logic [7:0] data);
        i_wb_cyc  = cyc;
        i_wb_stb  = stb;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = data;
        #1;
    endtask

    task automatic bus_idle();
        bus_req(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic do_read(input logic [1:0] addr, input logic [7:0] exp, input string tag);
        bus_req(1'b1, 1'b1, 1'b0, addr, 8'h00);
        check({tag, "_stall"}, o_wb_stall, 1'b0);
        step();
        check({tag, "_ack"}, o_wb_ack, 1'b1);
        check({tag, "_data"}, o_wb_data, exp);
        bus_idle();
        step();
        check({tag, "_ack_drop"}, o_wb_ack, 1'b0);
        check({tag, "_data_zero"}, o_wb_data, 8'h00);
    endtask

    // Write b to TXDATA, read STATUS as the frame starts, then follow the line.
    task automatic run_frame(input logic [7:0] b, input string tag);
        bus_req(1'b1, 1'b1, 1'b1, A_TXDATA, b);
        check({tag, "_wr_stall"}, o_wb_stall, 1'b0);
        step();
        check({tag, "_wr_ack"}, o_wb_ack, 1'b1);
        check({tag, "_wr_data"}, o_wb_data, 8'h00);
        check({tag, "_start_tx"}, o_uart_tx, 1'b0);
        bus_req(1'b1, 1'b1, 1'b0, A_STATUS, 8'h00);
        step();
        check({tag, "_stat_ack"}, o_wb_ack, 1'b1);
        check({tag, "_stat_busy"}, o_wb_data, STAT_BUSY);
        bus_idle();
        for (int c = 1; c < FRAME; c++) begin
            check({tag, "_tx"}, o_uart_tx, frame_bit(b, c / CPB));
            if (c == 2) check({tag, "_ack_single"}, o_wb_ack, 1'b0);
            step();
        end
        check({tag, "_tx_idle"}, o_uart_tx, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        bus_idle();
        repeat (3) step();
        check("rst_tx", o_uart_tx, 1'b1);
        check("rst_ack", o_wb_ack, 1'b0);
        check("rst_data", o_wb_data, 8'h00);
        check("rst_stall", o_wb_stall, 1'b0);
        reset = 1'b0;
        step();

        // Single frame 0x55, then STATUS idle and TXDATA readback
        run_frame(8'h55, "f55");
        do_read(A_STATUS, STAT_IDLE, "f55_stat_after");
        do_read(A_TXDATA, 8'h55, "f55_txdata");

        // Back-to-back accepted reads give back-to-back acks
        bus_req(1'b1, 1'b1, 1'b0, A_STATUS, 8'h00);
        step();
        check("rr_ack1", o_wb_ack, 1'b1);
        check("rr_data1", o_wb_data, STAT_IDLE);
        bus_req(1'b1, 1'b1, 1'b0, A_TXDATA, 8'h00);
        step();
        check("rr_ack2", o_wb_ack, 1'b1);
        check("rr_data2", o_wb_data, 8'h55);
        bus_idle();
        step();
        check("rr_ack_drop", o_wb_ack, 1'b0);

        // Second write stalls for the whole first frame, then follows with no gap
        bus_req(1'b1, 1'b1, 1'b1, A_TXDATA, 8'h3C);
        check("b2b_wr1_stall", o_wb_stall, 1'b0);
        step();
        check("b2b_wr1_ack", o_wb_ack, 1'b1);
        bus_req(1'b1, 1'b1, 1'b1, A_TXDATA, 8'hA3);
        for (int c = 0; c < FRAME; c++) begin
            check("b2b_stall", o_wb_stall, (c < FRAME - 1));
            if (c > 0) check("b2b_no_ack", o_wb_ack, 1'b0);
            check("b2b_tx1", o_uart_tx, frame_bit(8'h3C, c / CPB));
            step();
        end
        check("b2b_wr2_ack", o_wb_ack, 1'b1);
        bus_idle();
        for (int c = FRAME; c < 2 * FRAME; c++) begin
            check("b2b_tx2", o_uart_tx, frame_bit(8'hA3, (c - FRAME) / CPB));
            step();
        end
        check("b2b_tx_idle", o_uart_tx, 1'b1);
        do_read(A_STATUS, STAT_IDLE, "b2b_stat");
        do_read(A_TXDATA, 8'hA3, "b2b_txdata");

        // Reset one cycle at cycle 15 of a frame; a read in that cycle gets no ack
        bus_req(1'b1, 1'b1, 1'b1, A_TXDATA, 8'h81);
        step();
        check("rmid_wr_ack", o_wb_ack, 1'b1);
        bus_idle();
        for (int c = 0; c < 15; c++) begin
            check("rmid_tx", o_uart_tx, frame_bit(8'h81, c / CPB));
            step();
        end
        reset = 1'b1;
        bus_req(1'b1, 1'b1, 1'b0, A_STATUS, 8'h00);
        step();
        check("rmid_tx_high", o_uart_tx, 1'b1);
        check("rmid_no_ack", o_wb_ack, 1'b0);
        check("rmid_data", o_wb_data, 8'h00);
        reset = 1'b0;
        bus_idle();
        do_read(A_STATUS, STAT_IDLE, "rmid_stat");
        do_read(A_TXDATA, 8'h00, "rmid_txdata");
        run_frame(8'h0F, "f0f");
        do_read(A_TXDATA, 8'h0F, "f0f_txdata");

        // Reserved registers: acked, read zero, writes ignored
        do_read(2'd2, 8'h00, "rsv2_rd");
        check("rsv2_tx", o_uart_tx, 1'b1);
        bus_req(1'b1, 1'b1, 1'b1, 2'd3, 8'hFF);
        check("rsv3_stall", o_wb_stall, 1'b0);
        step();
        check("rsv3_ack", o_wb_ack, 1'b1);
        check("rsv3_data", o_wb_data, 8'h00);
        bus_idle();
        step();
        check("rsv3_ack_drop", o_wb_ack, 1'b0);
        for (int c = 0; c < 8; c++) begin
            check("rsv3_tx", o_uart_tx, 1'b1);
            step();
        end
        do_read(A_TXDATA, 8'h0F, "rsv3_txdata");

        // Strobe without cycle is ignored
        bus_req(1'b0, 1'b1, 1'b1, A_TXDATA, 8'h00);
        check("nocyc_stall", o_wb_stall, 1'b0);
        step();
        check("nocyc_ack", o_wb_ack, 1'b0);
        check("nocyc_tx", o_uart_tx, 1'b1);
        step();
        check("nocyc_tx2", o_uart_tx, 1'b1);
        bus_idle();
        do_read(A_TXDATA, 8'h0F, "nocyc_txdata");
        do_read(A_STATUS, STAT_IDLE, "nocyc_stat");

`ifdef WB_UART_PARITY_EN
        // 0x07 has three ones, so the even-parity bit is 1
        run_frame(8'h07, "par07");
        do_read(A_STATUS, STAT_IDLE, "par07_stat");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
